axis_spi_slave: RTL and testbench

AXIS_SPI_SLAVE -- requirements
Module: axis_spi_slave

---
 rtl/axis_spi_pkg.sv | 20 ++
 rtl/axis_if.sv | 11 +
 rtl/spi_sync_edge.sv | 30 +++
 rtl/axis_spi_slave.sv | 188 ++++++++++++++++++
 tb/tb_axis_spi_slave.sv | 356 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axis_spi_pkg.sv
// Shared types and helpers for the AXI-Stream SPI slave.
// Mode decode follows the usual CPOL/CPHA bit packing.
package axis_spi_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  localparam int SYNC_DEPTH = 2;

  function automatic logic cpol(input int mode);
    return mode[1];
  endfunction

  function automatic logic cpha(input int mode);
    return mode[0];
  endfunction

endpackage

// File: rtl/axis_if.sv
// Minimal AXI-Stream bundle: data, valid, ready.
interface axis_if #(
  parameter int DW = 8
);
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/spi_sync_edge.sv
// Multi-FF synchronizer with rise/fall pulses on the synced level.
module spi_sync_edge
  import axis_spi_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic arst_i,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);
  logic [SYNC_DEPTH-1:0] sync_q;
  logic                  prev_q;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      sync_q <= {SYNC_DEPTH{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_DEPTH-2:0], d_i};
      prev_q <= sync_q[SYNC_DEPTH-1];
    end
  end

  assign q_o    = sync_q[SYNC_DEPTH-1];
  assign rise_o = q_o & ~prev_q;
  assign fall_o = ~q_o & prev_q;
endmodule

// File: rtl/axis_spi_slave.sv
// SPI slave oversampled on clk_i, bridging serial words to AXI-Stream.
// One-entry TX buffer feeds MISO; RX words are offered on m_axis.
module axis_spi_slave
  import axis_spi_pkg::*;
#(
  parameter int SPI_MODE   = 0,
  parameter int DATA_WIDTH = 8
) (
  input  logic   clk_i,
  input  logic   arst_i,
  input  logic   spi_clk_i,
  input  logic   spi_cs_i,
  input  logic   spi_mosi_i,
  output logic   spi_miso_o,
  output logic   spi_miso_oe_o,
  axis_if.slave  s_axis,
  axis_if.master m_axis,
  output logic   underrun_o,
  output logic   overrun_o
);
  localparam logic CPOL = cpol(SPI_MODE);
  localparam logic CPHA = cpha(SPI_MODE);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  logic sclk_s, sclk_rise, sclk_fall;
  logic cs_s, cs_rise, cs_fall;
  logic [SYNC_DEPTH-1:0] mosi_q;
  logic mosi_s;

  spi_sync_edge #(.RST_VAL(CPOL)) u_sclk (
    .clk_i  (clk_i),
    .arst_i (arst_i),
    .d_i    (spi_clk_i),
    .q_o    (sclk_s),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b1)) u_cs (
    .clk_i  (clk_i),
    .arst_i (arst_i),
    .d_i    (spi_cs_i),
    .q_o    (cs_s),
    .rise_o (cs_rise),
    .fall_o (cs_fall)
  );

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) mosi_q <= '0;
    else        mosi_q <= {mosi_q[SYNC_DEPTH-2:0], spi_mosi_i};
  end
  assign mosi_s = mosi_q[SYNC_DEPTH-1];

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  rx_q, rx_d, tx_q, tx_d;
  logic [W-1:0]  buf_q, buf_d, mdata_q, mdata_d;
  logic bufv_q, bufv_d, mvalid_q, mvalid_d;
  logic pend_q, pend_d, ufp_q, ufp_d;
  logic und_q, und_d, ovr_q, ovr_d;
  logic armed_q, armed_d;
  logic [1:0] init_q, init_d;
  logic lead, trail, smp, shf, start, load, s_rdy;

  assign lead  = CPOL ? sclk_fall : sclk_rise;
  assign trail = CPOL ? sclk_rise : sclk_fall;
  assign smp   = (state_q == ACTIVE) && (CPHA ? trail : lead);
  assign shf   = (state_q == ACTIVE) && (CPHA ? lead : trail);
  // A CS fall is trusted only once CS was seen idle after reset
  assign start = cs_fall && armed_q && (state_q == IDLE);
  assign s_rdy = !bufv_q && (init_q != 2'd0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rx_d     = rx_q;
    tx_d     = tx_q;
    buf_d    = buf_q;
    bufv_d   = bufv_q;
    mdata_d  = mdata_q;
    mvalid_d = mvalid_q;
    pend_d   = pend_q;
    ufp_d    = ufp_q;
    und_d    = 1'b0;
    ovr_d    = 1'b0;
    load     = 1'b0;
    init_d   = (init_q == 2'd3) ? init_q : init_q + 2'd1;
    armed_d  = armed_q | ((init_q == 2'd3) && cs_s && (sclk_s == CPOL));
    if (mvalid_q && m_axis.tready) mvalid_d = 1'b0;
    if (start) begin
      state_d = ACTIVE;
      cnt_d   = '0;
      rx_d    = '0;
      pend_d  = 1'b0;
      ufp_d   = 1'b0;
      load    = 1'b1;
      und_d   = !bufv_q;
    end else if ((state_q == ACTIVE) && cs_rise) begin
      state_d = IDLE;
      cnt_d   = '0;
      pend_d  = 1'b0;
      ufp_d   = 1'b0;
    end else begin
      if (smp) begin
        rx_d = {rx_q[W-2:0], mosi_s};
        if (ufp_q) begin
          und_d = 1'b1;
          ufp_d = 1'b0;
        end
        if (cnt_q == LAST) begin
          cnt_d  = '0;
          pend_d = 1'b1;
          if (mvalid_q && !m_axis.tready) begin
            ovr_d = 1'b1;
          end else begin
            mdata_d  = rx_d;
            mvalid_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      // Next word loads on the first drive edge after wrap; an empty
      // buffer is only flagged once that word really gets sampled.
      if (shf) begin
        if (pend_q) begin
          load   = 1'b1;
          pend_d = 1'b0;
          ufp_d  = !bufv_q;
        end else if (cnt_q != '0) begin
          tx_d = {tx_q[W-2:0], 1'b0};
        end
      end
    end
    if (load) begin
      tx_d   = bufv_q ? buf_q : '0;
      bufv_d = 1'b0;
    end
    if (s_axis.tvalid && s_rdy) begin
      buf_d  = s_axis.tdata;
      bufv_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rx_q     <= '0;
      tx_q     <= '0;
      buf_q    <= '0;
      bufv_q   <= 1'b0;
      mdata_q  <= '0;
      mvalid_q <= 1'b0;
      pend_q   <= 1'b0;
      ufp_q    <= 1'b0;
      und_q    <= 1'b0;
      ovr_q    <= 1'b0;
      armed_q  <= 1'b0;
      init_q   <= 2'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rx_q     <= rx_d;
      tx_q     <= tx_d;
      buf_q    <= buf_d;
      bufv_q   <= bufv_d;
      mdata_q  <= mdata_d;
      mvalid_q <= mvalid_d;
      pend_q   <= pend_d;
      ufp_q    <= ufp_d;
      und_q    <= und_d;
      ovr_q    <= ovr_d;
      armed_q  <= armed_d;
      init_q   <= init_d;
    end
  end

  assign spi_miso_oe_o = (state_q == ACTIVE);
  assign spi_miso_o    = spi_miso_oe_o & tx_q[W-1];
  assign s_axis.tready = s_rdy;
  assign m_axis.tdata  = mdata_q;
  assign m_axis.tvalid = mvalid_q;
  assign underrun_o    = und_q;
  assign overrun_o     = ovr_q;
endmodule

// File: tb/tb_axis_spi_slave.sv
// Directed bench: a mode 0 and a mode 3 slave driven by SPI master tasks.
module tb_axis_spi_slave;
  logic clk = 1'b0;
  logic arst;
  logic sclk0, cs0, mosi0, miso0, oe0, und0, ovr0;
  logic sclk3, cs3, mosi3, miso3, oe3, und3, ovr3;

  axis_if #(.DW(8)) s0 ();
  axis_if #(.DW(8)) m0 ();
  axis_if #(.DW(8)) s3 ();
  axis_if #(.DW(8)) m3 ();

  int tests = 0;
  int fails = 0;
  int und_n0 = 0;
  int ovr_n0 = 0;
  int und_n3 = 0;
  int ovr_n3 = 0;
  logic [7:0] beats0[$];
  logic [7:0] beats3[$];

  axis_spi_slave #(.SPI_MODE(0), .DATA_WIDTH(8)) u_dut0 (
    .clk_i(clk), .arst_i(arst),
    .spi_clk_i(sclk0), .spi_cs_i(cs0), .spi_mosi_i(mosi0),
    .spi_miso_o(miso0), .spi_miso_oe_o(oe0),
    .s_axis(s0), .m_axis(m0),
    .underrun_o(und0), .overrun_o(ovr0)
  );

  axis_spi_slave #(.SPI_MODE(3), .DATA_WIDTH(8)) u_dut3 (
    .clk_i(clk), .arst_i(arst),
    .spi_clk_i(sclk3), .spi_cs_i(cs3), .spi_mosi_i(mosi3),
    .spi_miso_o(miso3), .spi_miso_oe_o(oe3),
    .s_axis(s3), .m_axis(m3),
    .underrun_o(und3), .overrun_o(ovr3)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (und0) und_n0 <= und_n0 + 1;
    if (ovr0) ovr_n0 <= ovr_n0 + 1;
    if (und3) und_n3 <= und_n3 + 1;
    if (ovr3) ovr_n3 <= ovr_n3 + 1;
    if (m0.tvalid && m0.tready) beats0.push_back(m0.tdata);
    if (m3.tvalid && m3.tready) beats3.push_back(m3.tdata);
  end

  task automatic bits0(input logic [7:0] d, input int n, output logic [7:0] r);
    r = 8'h00;
    for (int i = 7; i > 7 - n; i--) begin
      mosi0 = d[i];
      repeat (4) @(negedge clk);
      sclk0 = 1'b1;
      r[i] = miso0;
      repeat (4) @(negedge clk);
      sclk0 = 1'b0;
    end
  endtask

  task automatic bits3(input logic [7:0] d, output logic [7:0] r);
    r = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      sclk3 = 1'b0;
      mosi3 = d[i];
      repeat (4) @(negedge clk);
      sclk3 = 1'b1;
      r[i] = miso3;
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic push0(input logic [7:0] d);
    s0.tdata = d;
    s0.tvalid = 1'b1;
    for (int k = 0; k < 100 && !s0.tready; k++) @(negedge clk);
    tests++;
    if (s0.tready !== 1'b1) begin
      fails++;
      $display("FAIL push0_timeout tready=%b want 1", s0.tready);
    end
    @(negedge clk);
    s0.tvalid = 1'b0;
  endtask

  task automatic push3(input logic [7:0] d);
    s3.tdata = d;
    s3.tvalid = 1'b1;
    for (int k = 0; k < 100 && !s3.tready; k++) @(negedge clk);
    tests++;
    if (s3.tready !== 1'b1) begin
      fails++;
      $display("FAIL push3_timeout tready=%b want 1", s3.tready);
    end
    @(negedge clk);
    s3.tvalid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    tests++;
    if ({miso0, oe0, und0, ovr0} !== 4'b0000) begin
      fails++;
      $display("FAIL rst_outs0 got %b want 0000", {miso0, oe0, und0, ovr0});
    end
    tests++;
    if ({miso3, oe3, und3, ovr3} !== 4'b0000) begin
      fails++;
      $display("FAIL rst_outs3 got %b want 0000", {miso3, oe3, und3, ovr3});
    end
    tests++;
    if ({m0.tvalid, s0.tready, m3.tvalid, s3.tready} !== 4'b0000) begin
      fails++;
      $display("FAIL rst_axis got %b want 0000",
               {m0.tvalid, s0.tready, m3.tvalid, s3.tready});
    end
    arst = 1'b0;
    #1;
    tests++;
    if (s0.tready !== 1'b0) begin
      fails++;
      $display("FAIL rst_rdy_early got %b want 0", s0.tready);
    end
    @(posedge clk);
    #1;
    tests++;
    if (s0.tready !== 1'b1) begin
      fails++;
      $display("FAIL rst_rdy_late got %b want 1", s0.tready);
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_basic();
    int u, o, nb;
    logic [7:0] r;
    u = und_n0;
    o = ovr_n0;
    nb = beats0.size();
    push0(8'hA5);
    cs0 = 1'b0;
    repeat (4) @(negedge clk);
    tests++;
    if ({oe0, miso0} !== 2'b11) begin
      fails++;
      $display("FAIL basic_msb oe/miso got %b want 11", {oe0, miso0});
    end
    bits0(8'h3C, 8, r);
    repeat (4) @(negedge clk);
    cs0 = 1'b1;
    repeat (8) @(negedge clk);
    tests++;
    if (r !== 8'hA5) begin
      fails++;
      $display("FAIL basic_miso got %h want a5", r);
    end
    tests++;
    if (beats0.size() != nb + 1 || beats0[nb] !== 8'h3C) begin
      fails++;
      $display("FAIL basic_rx beats=%0d want %0d (data 3c)", beats0.size(), nb + 1);
    end
    tests++;
    if (und_n0 - u != 0 || ovr_n0 - o != 0) begin
      fails++;
      $display("FAIL basic_err und=%0d ovr=%0d want 0 0", und_n0 - u, ovr_n0 - o);
    end
    tests++;
    if ({oe0, miso0} !== 2'b00) begin
      fails++;
      $display("FAIL basic_idle oe/miso got %b want 00", {oe0, miso0});
    end
  endtask

  task automatic test_loopback();
    int u, o, nb;
    logic [7:0] r1, r2;
    u = und_n3;
    o = ovr_n3;
    nb = beats3.size();
    push3(8'h96);
    cs3 = 1'b0;
    repeat (6) @(negedge clk);
    push3(8'h3F);
    bits3(8'h5A, r1);
    bits3(8'hC3, r2);
    cs3 = 1'b1;
    repeat (8) @(negedge clk);
    tests++;
    if (r1 !== 8'h96 || r2 !== 8'h3F) begin
      fails++;
      $display("FAIL loop_miso got %h %h want 96 3f", r1, r2);
    end
    tests++;
    if (beats3.size() != nb + 2 || beats3[nb] !== 8'h5A || beats3[nb+1] !== 8'hC3) begin
      fails++;
      $display("FAIL loop_rx beats=%0d want %0d (5a c3)", beats3.size(), nb + 2);
    end
    tests++;
    if (und_n3 - u != 0 || ovr_n3 - o != 0) begin
      fails++;
      $display("FAIL loop_err und=%0d ovr=%0d want 0 0", und_n3 - u, ovr_n3 - o);
    end
  endtask

  task automatic test_underrun();
    int u, nb;
    logic [7:0] r;
    u = und_n0;
    nb = beats0.size();
    cs0 = 1'b0;
    repeat (4) @(negedge clk);
    bits0(8'hFF, 8, r);
    repeat (4) @(negedge clk);
    cs0 = 1'b1;
    repeat (8) @(negedge clk);
    tests++;
    if (r !== 8'h00) begin
      fails++;
      $display("FAIL under_miso got %h want 00", r);
    end
    tests++;
    if (und_n0 - u != 1) begin
      fails++;
      $display("FAIL under_pulse got %0d want 1", und_n0 - u);
    end
    tests++;
    if (beats0.size() != nb + 1 || beats0[nb] !== 8'hFF) begin
      fails++;
      $display("FAIL under_rx beats=%0d want %0d (ff)", beats0.size(), nb + 1);
    end
  endtask

  task automatic test_overrun();
    int o, nb;
    logic [7:0] r;
    o = ovr_n0;
    nb = beats0.size();
    m0.tready = 1'b0;
    cs0 = 1'b0;
    repeat (4) @(negedge clk);
    bits0(8'h11, 8, r);
    bits0(8'h22, 8, r);
    repeat (4) @(negedge clk);
    cs0 = 1'b1;
    repeat (8) @(negedge clk);
    tests++;
    if (m0.tvalid !== 1'b1 || m0.tdata !== 8'h11) begin
      fails++;
      $display("FAIL over_hold got v=%b d=%h want 1 11", m0.tvalid, m0.tdata);
    end
    tests++;
    if (ovr_n0 - o != 1) begin
      fails++;
      $display("FAIL over_pulse got %0d want 1", ovr_n0 - o);
    end
    m0.tready = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if (beats0.size() != nb + 1 || beats0[nb] !== 8'h11 || m0.tvalid !== 1'b0) begin
      fails++;
      $display("FAIL over_drain beats=%0d v=%b want %0d 0", beats0.size(), m0.tvalid, nb + 1);
    end
  endtask

  task automatic test_cs_abort();
    int nb;
    logic [7:0] r;
    nb = beats0.size();
    cs0 = 1'b0;
    repeat (4) @(negedge clk);
    bits0(8'hF0, 4, r);
    repeat (4) @(negedge clk);
    cs0 = 1'b1;
    repeat (8) @(negedge clk);
    tests++;
    if (beats0.size() != nb) begin
      fails++;
      $display("FAIL abort_none beats=%0d want %0d", beats0.size(), nb);
    end
    cs0 = 1'b0;
    repeat (4) @(negedge clk);
    bits0(8'h81, 8, r);
    repeat (4) @(negedge clk);
    cs0 = 1'b1;
    repeat (8) @(negedge clk);
    tests++;
    if (beats0.size() != nb + 1 || beats0[nb] !== 8'h81) begin
      fails++;
      $display("FAIL abort_full beats=%0d want %0d (81)", beats0.size(), nb + 1);
    end
  endtask

  task automatic test_reset_mid();
    int nb;
    logic [7:0] r;
    nb = beats0.size();
    cs0 = 1'b0;
    repeat (4) @(negedge clk);
    bits0(8'hAA, 4, r);
    arst = 1'b1;
    #1;
    tests++;
    if ({oe0, miso0, s0.tready, m0.tvalid, und0, ovr0} !== 6'b000000) begin
      fails++;
      $display("FAIL rstmid_outs got %b want 000000",
               {oe0, miso0, s0.tready, m0.tvalid, und0, ovr0});
    end
    repeat (3) @(negedge clk);
    arst = 1'b0;
    bits0(8'hA0, 4, r);
    repeat (4) @(negedge clk);
    cs0 = 1'b1;
    repeat (8) @(negedge clk);
    tests++;
    if (beats0.size() != nb || s0.tready !== 1'b1) begin
      fails++;
      $display("FAIL rstmid_none beats=%0d rdy=%b want %0d 1", beats0.size(), s0.tready, nb);
    end
    cs0 = 1'b0;
    repeat (4) @(negedge clk);
    bits0(8'h42, 8, r);
    repeat (4) @(negedge clk);
    cs0 = 1'b1;
    repeat (8) @(negedge clk);
    tests++;
    if (beats0.size() != nb + 1 || beats0[nb] !== 8'h42) begin
      fails++;
      $display("FAIL rstmid_full beats=%0d want %0d (42)", beats0.size(), nb + 1);
    end
  endtask

  initial begin
    arst = 1'b1;
    sclk0 = 1'b0;
    cs0 = 1'b1;
    mosi0 = 1'b0;
    sclk3 = 1'b1;
    cs3 = 1'b1;
    mosi3 = 1'b0;
    s0.tdata = 8'h00;
    s0.tvalid = 1'b0;
    m0.tready = 1'b1;
    s3.tdata = 8'h00;
    s3.tvalid = 1'b0;
    m3.tready = 1'b1;
    test_reset();
    test_basic();
    test_loopback();
    test_underrun();
    test_overrun();
    test_cs_abort();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
